seq_restoring_divider: RTL and testbench
========================================

// Module: seq_restoring_divider
// PURPOSE
//   Iterative unsigned restoring divider; the inverse of the team's adder datapath.
//   One subtract-and-restore step per clock.
//   Sits beside the CLA adder blocks as the multi-cycle arithmetic unit.
//   Valid/ready handshake on input and output; one operation in flight.
// PARAMETERS
//   WIDTH      16   operand/result width in bits (>= 2)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      synchronous, active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      divider can accept (state IDLE)
//   dividend   in   WIDTH  unsigned dividend
//   divisor    in   WIDTH  unsigned divisor
//   out_valid  out  1      result valid (state DONE)
//   out_ready  in   1      consumer accepts result
//   quotient   out  WIDTH  unsigned quotient
//   remainder  out  WIDTH  unsigned remainder
//   div_zero   out  1      divisor was zero for this result
// BEHAVIOUR
//   Reset (rst_n low at a clk edge):
//   - state=IDLE; in_ready=1.
//   - out_valid, quotient, remainder, div_zero all 0.
//   - An in-flight operation is discarded and no result is produced.
//   FSM IDLE -> BUSY -> DONE -> IDLE:
//   - IDLE: in_ready=1. On in_valid&in_ready, latch divisor and dividend into the Q shift
//     register; clear rem (WIDTH bits); cnt=WIDTH; div_zero=(divisor==0); go to BUSY.
//   - BUSY: in_ready=0. Each cycle:
//     - trial = {rem,Q[MSB]} - {1'b0,divisor}, computed WIDTH+1 bits wide.
//     - No borrow: rem=trial[WIDTH-1:0], Q={Q[W-2:0],1}.
//     - Borrow: rem={rem[W-2:0],Q[MSB]}, Q={Q[W-2:0],0}.
//     - cnt decrements; leaving the cnt==1 step goes to DONE.
//   - DONE: out_valid=1; quotient=Q and remainder=rem are held stable.
//     out_valid&out_ready -> IDLE and out_valid drops next cycle.
//   Latency: handshake edge t0, out_valid high after edge t0+WIDTH.
//   Throughput: one result per WIDTH+2 cycles minimum.
//   Backpressure: DONE is held indefinitely while out_ready=0; outputs must not change.
//   in_ready is 0 in BUSY and DONE. No new operation is accepted in the cycle out_valid
//   falls, because in_ready comes from registered state.
//   Divide-by-zero result: quotient = all ones, remainder = dividend, div_zero=1.
//   quotient/remainder are don't-care outside DONE but must not be X after reset.
// CONFIGURATION
//   Macro DIV_ZERO_EARLY_EN.
//   - Defined: a zero divisor seen at accept skips BUSY and goes directly to DONE
//     (out_valid after edge t0+1). The result is loaded directly.
//   - Undefined: a zero divisor runs the full WIDTH iterations. The same q/r fall out
//     naturally, and div_zero is still reported.
//   Results are identical either way; only latency differs.
// STRUCTURE
//   Package div_pkg:
//   - state enum {IDLE, BUSY, DONE};
//   - localparam function for cnt width = $clog2(WIDTH+1).
//   Sub-module div_sub_step:
//   - combinational (WIDTH+1)-bit subtractor;
//   - outputs diff[WIDTH-1:0] and borrow;
//   - instanced once in the BUSY datapath.
// TESTING (WIDTH=16)
//   100/7                         -> q=14, r=2, div_zero=0; out_valid exactly 16 cycles after accept.
//   0xFFFF/1, then 3/9            -> q=0xFFFF, r=0; then q=0, r=3; in_ready low throughout BUSY and DONE.
//   5/0                           -> q=0xFFFF, r=5, div_zero=1; latency 1 with DIV_ZERO_EARLY_EN, 16 without.
//   1000/33, out_ready low 5 cycles in DONE -> q=30, r=10 held stable; out_valid stays 1; no new accept.
//   rst_n low at BUSY cycle 8     -> next cycle IDLE, in_ready=1, all outputs 0; a following 9/4 gives q=2, r=1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  // Controller states: accept operands, iterate, present result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed for an iteration counter that must hold the value w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division trial subtraction: (WIDTH+1)-bit minuend minus a
// zero-extended WIDTH-bit divisor, reporting the low WIDTH bits and the borrow.
module div_sub_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH:0]   minuend_i,
  input  logic [WIDTH-1:0] subtrahend_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  // Only the low bits survive; the partial remainder stays below the divisor.
  assign diff_o   = minuend_i[WIDTH-1:0] - subtrahend_i;
  assign borrow_o = (minuend_i < {1'b0, subtrahend_i});

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one subtract-and-restore step per clock,
// valid/ready on both sides with a single operation in flight.
// Optional macro DIV_ZERO_EARLY_EN: a zero divisor skips the iterations and the
// result is loaded in one cycle instead of WIDTH.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] step_diff;
  logic             step_borrow;

  // Trial subtraction of the divisor from the shifted partial remainder.
  div_sub_step #(.WIDTH(WIDTH)) u_step (
    .minuend_i    ({rem_q, q_q[WIDTH-1]}),
    .subtrahend_i (dvsr_q),
    .diff_o       (step_diff),
    .borrow_o     (step_borrow)
  );

  // Next-state and datapath update for the IDLE/BUSY/DONE controller.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvsr_d  = divisor;
          q_d     = dividend;
          rem_d   = '0;
          cnt_d   = CW'(WIDTH);
          dz_d    = (divisor == '0);
          state_d = BUSY;
        end
      end
      BUSY: begin
`ifdef DIV_ZERO_EARLY_EN
        if (dz_q) begin
          // Zero divisor: load the all-ones quotient and pass the dividend through.
          rem_d   = q_q;
          q_d     = '1;
          state_d = DONE;
        end else begin
`else
        begin
`endif
          if (!step_borrow) begin
            rem_d = step_diff;
            q_d   = {q_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = {rem_q[WIDTH-2:0], q_q[WIDTH-1]};
            q_d   = {q_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State, datapath and handshake registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      q_q         <= '0;
      rem_q       <= '0;
      dvsr_q      <= '0;
      cnt_q       <= '0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      rem_q       <= rem_d;
      dvsr_q      <= dvsr_d;
      cnt_q       <= cnt_d;
      dz_q        <= dz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = q_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=16): directed cases plus
// random operands against an arithmetic reference model.
module tb_seq_restoring_divider;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int n_checks = 0;
  int n_fails  = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer division with the divide-by-zero convention.
  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? {W{1'b1}} : W'(a / b);
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? a : W'(a % b);
  endfunction

  function automatic int ref_lat(input logic [W-1:0] b);
`ifdef DIV_ZERO_EARLY_EN
    return (b == 0) ? 1 : W;
`else
    return W;
`endif
  endfunction

  // One full transaction; hold = cycles of out_ready low while in DONE.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    int n;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    eq = ref_q(a, b);
    er = ref_r(a, b);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    step();
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    n = 0;
    while (!out_valid && n < 100) begin
      if (in_ready !== 1'b0) chk("in_ready_busy", 32'(in_ready), 32'd0);
      step();
      n++;
    end
    chk("latency", 32'(n), 32'(ref_lat(b)));
    chk("quotient", 32'(quotient), 32'(eq));
    chk("remainder", 32'(remainder), 32'(er));
    chk("div_zero", 32'(div_zero), 32'(b == 0));
    chk("in_ready_done", 32'(in_ready), 32'd0);
    if (hold > 0) begin
      in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        step();
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_q", 32'(quotient), 32'(eq));
        chk("hold_r", 32'(remainder), 32'(er));
        chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("idle_no_valid", 32'(out_valid), 32'd0);

    // Directed cases
    do_op(16'd100, 16'd7, 0);
    do_op(16'hFFFF, 16'd1, 0);
    do_op(16'd3, 16'd9, 0);
    do_op(16'd5, 16'd0, 0);
    do_op(16'd1000, 16'd33, 5);
    do_op(16'd0, 16'd5, 0);
    do_op(16'hFFFF, 16'hFFFF, 0);
    do_op(16'h1234, 16'hFFFF, 1);

    // Reset in the middle of an operation discards it
    in_valid = 1'b1;
    dividend = 16'd40000;
    divisor  = 16'd7;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("mid_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_quotient", 32'(quotient), 32'd0);
    chk("mid_rst_remainder", 32'(remainder), 32'd0);
    chk("mid_rst_div_zero", 32'(div_zero), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid !== 1'b0) chk("mid_rst_no_result", 32'(out_valid), 32'd0);
    end
    do_op(16'd9, 16'd4, 0);

    // Random operands, with small and zero divisors mixed in
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      case (i % 4)
        0:       rb = W'($urandom);
        1:       rb = W'($urandom_range(1, 15));
        2:       rb = (i % 8 == 2) ? '0 : W'($urandom_range(1, 255));
        default: rb = W'($urandom) >> $urandom_range(0, 15);
      endcase
      do_op(ra, rb, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
